// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-side push channel, flush, decode-side pop channel and
// the occupancy count, bundled between the instruction fetch queue and its
// neighbours.
//   master: the fetch/decode environment (drives pushes, flush, out_ready)
//   slave : the queue itself
interface if_id_queue_if #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_pc;
    logic [W-1:0]  in_inst;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_pc;
    logic [W-1:0]  out_inst;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry circular FIFO of {pc, inst} pairs between fetch and
// decode. Head entry is presented from registered storage; a flush empties the
// queue in one cycle and drops whatever fetch presents in that cycle.
// Optional macro IFQ_BYPASS_EN: when the queue is empty the incoming pair is
// forwarded combinationally to decode (zero-cycle latency) and, if decode takes
// it in the same cycle, it is never written.
module if_id_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    if_id_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2*W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0] wr_sel;

    logic             not_empty;
    logic             not_full;
    logic             byp_take;
    logic             push_wr;
    logic             pop_mem;
    logic [2*W-1:0]   head_pair;

    assign not_empty = (count_q != '0);
    assign not_full  = (count_q != CW'(DEPTH));
    assign head_pair = mem_q[head_q];

    // in_ready depends only on occupancy, so a full queue refuses a push
    // even when decode pops in the same cycle.
    assign bus.in_ready = not_full;
    assign bus.count    = count_q;

`ifdef IFQ_BYPASS_EN
    logic byp_active;
    // Empty queue with a live input: forward it straight to decode.
    assign byp_active    = rst_n && !not_empty && bus.in_valid && !bus.flush;
    assign byp_take      = byp_active && bus.out_ready;
    assign bus.out_valid = !bus.flush && (not_empty || byp_active);
    assign bus.out_pc    = byp_active ? bus.in_pc   : head_pair[2*W-1:W];
    assign bus.out_inst  = byp_active ? bus.in_inst : head_pair[W-1:0];
`else
    assign byp_take      = 1'b0;
    assign bus.out_valid = not_empty;
    assign bus.out_pc    = head_pair[2*W-1:W];
    assign bus.out_inst  = head_pair[W-1:0];
`endif

    // A pair consumed through the bypass path is never written to storage.
    assign push_wr = bus.in_valid && not_full && !bus.flush && !byp_take;
    assign pop_mem = not_empty && bus.out_ready && !bus.flush;

    // One write strobe per storage slot, selected by the tail pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_wr && (tail_q == PW'(gi));
        end
    endgenerate

    // Next pointer/occupancy; flush overrides any push or pop this cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_wr) tail_d = tail_q + PW'(1);
            if (pop_mem) head_d = head_q + PW'(1);
            case ({push_wr, pop_mem})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so no stale pair survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) mem_q[i] <= {bus.in_pc, bus.in_inst};
            end
        end
    end
endmodule
